crc_calc: RTL and testbench
===========================

# crc_calc

Byte-serial Ethernet CRC-32 (FCS) generator for the Ethernet receive path. It accumulates one octet per enabled clock and continuously presents the finished FCS value. The surrounding frame logic uses it to compute the CRC over a received frame, for example an ARP frame. That logic clears the block through its reset between frames and samples the output after the last byte.

## Interface
- No parameters. Polynomial, initial value and final XOR are fixed (see Operation).
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  reset: asynchronous, active-high. Loads CRC register with seed.
- i_enbl  in  1  byte strobe; when high, i_data_in is folded into CRC on this edge.
- i_data_in  in  8  frame octet; bit 0 is the first bit on the wire.
- o_crc_out  out  32  running FCS, final XOR applied; o_crc_out[7:0] is the first FCS octet transmitted.

## Operation
- Algorithm is CRC-32/ISO-HDLC (IEEE 802.3):
  - polynomial 0x04C11DB7, processed reflected (LSB-first, equivalent shift constant 0xEDB88320);
  - init 0xFFFFFFFF;
  - reflected in and out;
  - xorout 0xFFFFFFFF.
- Internal 32-bit register crc_r:
  - i_reset high: crc_r = 0xFFFFFFFF.
  - i_enbl high: crc_r = next_crc8(crc_r, i_data_in).
  - otherwise: crc_r holds.
- next_crc8 is a fully combinational 8-bit-parallel update. It is equivalent to 8 iterations of the following, for bits b = i_data_in[0] first through i_data_in[7] last:
  - fb = c[0] ^ b;
  - c = (c >> 1) ^ (fb ? 0xEDB88320 : 0).
  - It is implemented as an unrolled XOR network or loop; no multi-cycle or bit-serial operation.
- o_crc_out = ~crc_r, combinational from the register; no extra output register.
- Frame boundaries are not detected internally. The user must pulse i_reset (or hold it) before each new frame. The reset input may be driven by registered logic ORed with the system reset.
- Residue check: after a frame's data bytes followed by its 4 FCS bytes (LSB first) are all enabled in, crc_r = 0xDEBB20E3 and o_crc_out = 0x2144DF1C. This is the good-frame indication for the receiver.
- No internal count limit; any number of bytes is accepted. State never saturates or wraps except through CRC arithmetic.

## Timing
- Reset values:
  - crc_r = 0xFFFFFFFF;
  - o_crc_out = 0x00000000, the CRC of an empty message.
- Latency: a byte presented with i_enbl high at edge N is reflected in o_crc_out immediately after edge N. One cycle of latency, one byte per cycle throughput, no back-pressure.
- Gaps are allowed: with i_enbl low, o_crc_out is stable for any number of cycles and the result is identical to gap-free streaming.
- Reset mid-frame: asynchronous. o_crc_out goes to 0x00000000 without waiting for a clock, and accumulated state is discarded.
- Reset deasserted with i_enbl high on the same edge: the byte is accepted normally. Reset asserted on that edge wins and the byte is lost.
- i_data_in is ignored when i_enbl is low; X on i_data_in while disabled must not propagate.

## Test plan
- Reset only, no enables -> o_crc_out = 0x00000000, stable for 10 cycles.
- Bytes "123456789" (0x31..0x39) on consecutive enabled cycles -> o_crc_out = 0xCBF43926 one edge after the last byte.
- Single byte 0x00 -> 0xD202EF8D. Then assert i_reset asynchronously mid-cycle -> 0x00000000 before the next edge.
- Same "123456789" with random i_enbl-low gaps and X on i_data_in during the gaps -> still 0xCBF43926.
- 42-byte ARP frame followed by its 4 computed FCS bytes (LSB first) -> o_crc_out = 0x2144DF1C. Flip any one data bit -> value differs.
- Back-to-back frames, reset pulsed one cycle between them -> second result matches its independent golden-model CRC, with no carry-over from the first frame.

Source files
------------

// File: rtl/crc_calc.sv
// Byte-parallel Ethernet CRC-32 (FCS) accumulator.
// One octet per enabled clock; o_crc_out is the finished FCS at all times.
module crc_calc (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enbl,
  input  logic [7:0]  i_data_in,
  output logic [31:0] o_crc_out
);

  localparam logic [31:0] POLY_REF = 32'hEDB88320;
  localparam logic [31:0] SEED     = 32'hFFFFFFFF;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_nxt;

  // Reflected update, wire bit 0 first; the loop unrolls into an XOR network.
  always_comb begin
    crc_nxt = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (crc_nxt[0] ^ i_data_in[i]) begin
        crc_nxt = (crc_nxt >> 1) ^ POLY_REF;
      end else begin
        crc_nxt = crc_nxt >> 1;
      end
    end
    crc_d = i_enbl ? crc_nxt : crc_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      crc_q <= SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc_out = ~crc_q;

endmodule

// File: tb/tb_crc_calc.sv
// Self-checking bench for crc_calc against a table-driven CRC-32 model
// that recomputes each whole message from scratch.
module tb_crc_calc;

  typedef logic [7:0] bq_t[$];

  logic        i_clk;
  logic        i_reset;
  logic        i_enbl;
  logic [7:0]  i_data_in;
  logic [31:0] o_crc_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] tbl [256];

  crc_calc dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enbl    (i_enbl),
    .i_data_in (i_data_in),
    .o_crc_out (o_crc_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] crc_ref(input bq_t msg);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (msg[k]) c = tbl[(c[7:0] ^ msg[k])] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [31:0] obs,
                        input logic [31:0] bad);
    checks++;
    assert (obs !== bad) else begin
      errors++;
      $error("FAIL %s: observed %h expected anything but %h", tag, obs, bad);
    end
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    i_enbl = 1'b1;
    i_data_in = b;
    @(posedge i_clk); #1;
    i_enbl = 1'b0;
    i_data_in = 'x;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic send(input bq_t msg, input bit gaps);
    foreach (msg[k]) begin
      put(msg[k]);
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    bq_t s9, arp, bad, f1, f2;
    logic [31:0] fcs;
    int bit_idx;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[i] = c;
    end

    i_reset = 1'b1;
    i_enbl = 1'b0;
    i_data_in = 'x;
    idle(2);
    i_reset = 1'b0;

    // Reset state, stable with no enables.
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      chk($sformatf("reset_idle%0d", k), o_crc_out, 32'h0);
    end

    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_check", crc_ref(s9), 32'hCBF43926);
    @(posedge i_clk); #1;
    send(s9, 1'b0);
    @(negedge i_clk);
    chk("check_123456789", o_crc_out, 32'hCBF43926);

    pulse_reset();
    put(8'h00);
    @(negedge i_clk);
    chk("single_zero", o_crc_out, 32'hD202EF8D);
    #2 i_reset = 1'b1;
    #1 chk("async_reset", o_crc_out, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    send(s9, 1'b1);
    @(negedge i_clk);
    chk("gapped_123456789", o_crc_out, 32'hCBF43926);
    idle(3);
    @(negedge i_clk);
    chk("gap_hold", o_crc_out, 32'hCBF43926);

    // ARP-like frame: broadcast dst, EtherType 0x0806.
    arp = {};
    for (int k = 0; k < 42; k++) arp.push_back(8'($urandom));
    for (int k = 0; k < 6; k++) arp[k] = 8'hFF;
    arp[12] = 8'h08;
    arp[13] = 8'h06;
    fcs = crc_ref(arp);
    pulse_reset();
    send(arp, 1'b0);
    @(negedge i_clk);
    chk("arp_fcs", o_crc_out, fcs);
    @(posedge i_clk); #1;
    for (int k = 0; k < 4; k++) put(fcs[8*k +: 8]);
    @(negedge i_clk);
    chk("arp_residue", o_crc_out, 32'h2144DF1C);

    bad = arp;
    bit_idx = $urandom_range(0, 42 * 8 - 1);
    bad[bit_idx / 8][bit_idx % 8] = ~bad[bit_idx / 8][bit_idx % 8];
    pulse_reset();
    send(bad, 1'b1);
    for (int k = 0; k < 4; k++) put(fcs[8*k +: 8]);
    @(negedge i_clk);
    chk_ne("arp_bitflip", o_crc_out, 32'h2144DF1C);

    // Back-to-back random frames with a one-cycle reset between them.
    for (int r = 0; r < 4; r++) begin
      f1 = {};
      f2 = {};
      for (int k = 0; k < $urandom_range(1, 60); k++)
        f1.push_back(8'($urandom));
      for (int k = 0; k < $urandom_range(1, 60); k++)
        f2.push_back(8'($urandom));
      pulse_reset();
      send(f1, r[0]);
      @(negedge i_clk);
      chk($sformatf("frame1_%0d", r), o_crc_out, crc_ref(f1));
      @(posedge i_clk); #1;
      pulse_reset();
      send(f2, r[1]);
      @(negedge i_clk);
      chk($sformatf("frame2_%0d", r), o_crc_out, crc_ref(f2));
      @(posedge i_clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
